// File: rtl/update_sequencer.sv
// Game-logic update sequencer: on each frame tick, starts the update phases one at a time,
// waits for each phase's done (bounded by a timeout), then issues one commit pulse.
//
// state  | meaning
// IDLE   | waiting for a tick with enable high
// START  | phase index latched; phase_start[p] registers out on the next cycle
// WAIT   | waiting for phase_done[p] or the wait limit
// COMMIT | one-cycle calculation_time pulse
module update_sequencer #(
  parameter int CLK           = 50000000,
  parameter int FPS           = 360,
  parameter int NUM_PHASES    = 4,
  parameter int PHASE_TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear_status,
  input  logic [NUM_PHASES-1:0] phase_done,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic                  calculation_time,
  output logic                  busy,
  output logic [7:0]            overrun_count,
  output logic                  timeout_flag
);

  localparam int TICK_PERIOD = CLK / FPS;
  localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int WW = (PHASE_TIMEOUT > 1) ? $clog2(PHASE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(PHASE_TIMEOUT - 1);
  localparam logic [2:0]    LAST_PHASE = 3'(NUM_PHASES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] START  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [1:0]            state;
  logic [2:0]            phase;
  logic [WW-1:0]         wait_cnt;
  logic                  done_sel;
  logic                  wait_limit;
  logic [NUM_PHASES-1:0] start_onehot;

  // Free-running frame timer, independent of enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Only the done bit of the phase being waited on is observed.
  always_comb begin
    done_sel     = 1'b0;
    start_onehot = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase == 3'(i)) begin
        done_sel = phase_done[i];
      end
      start_onehot[i] = (state == START) && (phase == 3'(i));
    end
  end

  assign wait_limit = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= 3'd0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && enable) begin
            phase <= 3'd0;
            state <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (done_sel || wait_limit) begin
            if (phase == LAST_PHASE) begin
              state <= COMMIT;
            end else begin
              phase <= phase + 3'd1;
              state <= START;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_start <= '0;
    end else begin
      phase_start <= start_onehot;
    end
  end

  assign busy             = (state != IDLE);
  assign calculation_time = (state == COMMIT);

  // Clear has priority over any same-cycle overrun or timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_count <= 8'd0;
      timeout_flag  <= 1'b0;
    end else if (clear_status) begin
      overrun_count <= 8'd0;
      timeout_flag  <= 1'b0;
    end else begin
      if (tick && busy && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if ((state == WAIT) && wait_limit && !done_sel) begin
        timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_update_sequencer.sv
// Bench for update_sequencer: plans each frame sequence from per-phase done delays,
// drives phase_done open-loop from that plan and compares every output every cycle.
module tb_update_sequencer;

  localparam int CLK_HZ = 40;
  localparam int FPS    = 4;
  localparam int NP     = 4;
  localparam int PT     = 8;
  localparam int TP     = CLK_HZ / FPS;
  localparam int MAXC   = 4600;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          clear_status = 1'b0;
  logic [NP-1:0] phase_done = '0;
  logic [NP-1:0] phase_start;
  logic          calculation_time;
  logic          busy;
  logic [7:0]    overrun_count;
  logic          timeout_flag;

  update_sequencer #(
    .CLK(CLK_HZ), .FPS(FPS), .NUM_PHASES(NP), .PHASE_TIMEOUT(PT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_status(clear_status),
    .phase_done(phase_done), .phase_start(phase_start),
    .calculation_time(calculation_time), .busy(busy),
    .overrun_count(overrun_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  logic [NP-1:0] drv_done [MAXC];
  bit            drv_en   [MAXC];
  bit            drv_clr  [MAXC];
  logic [NP-1:0] exp_start[MAXC];
  bit            exp_calc [MAXC];
  bit            exp_busy [MAXC];
  bit            ev_ovr   [MAXC];
  bit            ev_tmo   [MAXC];
  int            exp_ovr  [MAXC];
  bit            exp_tmo  [MAXC];
  int            wait_ph  [MAXC];
  logic [NP-1:0] obs_start[MAXC];
  logic          obs_calc [MAXC];
  logic          obs_busy [MAXC];
  logic [7:0]    obs_ovr  [MAXC];
  logic          obs_tmo  [MAXC];

  int n_checks = 0;
  int n_errors = 0;
  int dmode, en_mode, clr_pct, spur_pct;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, k, obs, expv);
    end
  endtask

  // Done delay in cycles after the phase_start pulse; -1 means never answered.
  function automatic int pick_delay(input int i);
    case (dmode)
      0: return 1;
      1: return (i == 1) ? -1 : 1;
      2: return -1;
      3: return (i == 0) ? 6 : 1;
      4: return (i == 2) ? -1 : 1;
      default: return ($urandom_range(99) < 25) ? -1 : int'($urandom_range(PT - 1));
    endcase
  endfunction

  task automatic plan(input int len, input int clr_at);
    int busy_end, s, e, d, commit, o;
    bit t;
    logic [NP-1:0] r;
    for (int k = 0; k < MAXC; k++) begin
      drv_done[k] = '0; drv_en[k] = 1'b0; drv_clr[k] = 1'b0;
      exp_start[k] = '0; exp_calc[k] = 1'b0; exp_busy[k] = 1'b0;
      ev_ovr[k] = 1'b0; ev_tmo[k] = 1'b0; wait_ph[k] = -1;
    end
    for (int k = 0; k < len; k++) begin
      case (en_mode)
        0: drv_en[k] = 1'b1;
        1: drv_en[k] = ($urandom_range(3) != 0);
        default: drv_en[k] = (k < TP);
      endcase
      drv_clr[k] = (k == clr_at) || (int'($urandom_range(99)) < clr_pct);
    end
    busy_end = -1;
    for (int k = 0; k < len; k++) begin
      if (k % TP == TP - 1) begin
        if (k <= busy_end) begin
          ev_ovr[k] = 1'b1;
        end else if (drv_en[k]) begin
          // Phase i pulses 2 cycles after the previous exit; commit 1 cycle after the last exit.
          s = k + 2;
          commit = 0;
          for (int i = 0; i < NP; i++) begin
            d = pick_delay(i);
            e = (d >= 0) ? s + d : s + PT - 1;
            exp_start[s][i] = 1'b1;
            for (int c = s; c <= e; c++) wait_ph[c] = i;
            if (d >= 0) drv_done[s + d][i] = 1'b1;
            else ev_tmo[e] = 1'b1;
            if (i < NP - 1) s = e + 2;
            else commit = e + 1;
          end
          exp_calc[commit] = 1'b1;
          for (int c = k + 1; c <= commit; c++) exp_busy[c] = 1'b1;
          busy_end = commit;
        end
      end
    end
    for (int k = 0; k < len + 50; k++) begin
      if (int'($urandom_range(99)) < spur_pct) begin
        r = NP'($urandom);
        if (wait_ph[k] >= 0) r[wait_ph[k]] = 1'b0;
        drv_done[k] = drv_done[k] | r;
      end
    end
    o = 0;
    t = 1'b0;
    for (int k = 0; k < len; k++) begin
      exp_ovr[k] = o;
      exp_tmo[k] = t;
      if (drv_clr[k]) begin
        o = 0;
        t = 1'b0;
      end else begin
        if (ev_ovr[k] && o < 255) o++;
        if (ev_tmo[k]) t = 1'b1;
      end
    end
  endtask

  task automatic run(input int len);
    for (int k = 0; k < len; k++) begin
      enable       = drv_en[k];
      clear_status = drv_clr[k];
      phase_done   = drv_done[k];
      @(negedge clk);
      obs_start[k] = phase_start;
      obs_calc[k]  = calculation_time;
      obs_busy[k]  = busy;
      obs_ovr[k]   = overrun_count;
      obs_tmo[k]   = timeout_flag;
      chk("phase_start", k, 32'(phase_start), 32'(exp_start[k]));
      chk("calculation_time", k, 32'(calculation_time), 32'(exp_calc[k]));
      chk("busy", k, 32'(busy), 32'(exp_busy[k]));
      chk("overrun_count", k, 32'(overrun_count), 32'(exp_ovr[k]));
      chk("timeout_flag", k, 32'(timeout_flag), 32'(exp_tmo[k]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_phase_start"}, -1, 32'(phase_start), 0);
    chk({tag, "_calc"}, -1, 32'(calculation_time), 0);
    chk({tag, "_busy"}, -1, 32'(busy), 0);
    chk({tag, "_ovr"}, -1, 32'(overrun_count), 0);
    chk({tag, "_tmo"}, -1, 32'(timeout_flag), 0);
  endtask

  // Reset is applied and released 1 time unit after a rising edge, so cycle 0 of the
  // following run has the tick counter at 0.
  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    clear_status = 1'b0;
    phase_done = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic int first_start(input int ph, input int len);
    for (int k = 0; k < len; k++) if (obs_start[k][ph] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int first_calc(input int len);
    for (int k = 0; k < len; k++) if (obs_calc[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_calc(input int len);
    int n = 0;
    for (int k = 0; k < len; k++) if (obs_calc[k] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    #2;
    // Every phase answers one cycle after its start pulse.
    dmode = 0; en_mode = 0; clr_pct = 0; spur_pct = 0;
    do_reset();
    plan(35, -1);
    run(35);
    for (int i = 0; i < NP; i++) chk($sformatf("order_start%0d", i), -1, first_start(i, 35), TP - 1 + 2 + 3 * i);
    chk("latency_commit", -1, first_calc(35), TP - 1 + 13);
    chk("busy_next_free_tick", -1, 32'(obs_busy[3 * TP - 1]), 0);

    // Phase 1 never answers: timeout path.
    dmode = 1;
    do_reset();
    plan(30, -1);
    run(30);
    chk("timeout_gap", -1, first_start(2, 30) - first_start(1, 30), PT + 1);
    chk("timeout_sticky", -1, 32'(obs_tmo[29]), 1);
    chk("commit_once", -1, count_calc(30), 1);

    // Nothing answers, single enabled tick, then a clear pulse.
    dmode = 2; en_mode = 2;
    do_reset();
    plan(53, 50);
    run(53);
    chk("overrun_three", -1, 32'(obs_ovr[48]), 3);
    chk("timeout_before_clear", -1, 32'(obs_tmo[48]), 1);
    chk("overrun_cleared", -1, 32'(obs_ovr[52]), 0);
    chk("timeout_cleared", -1, 32'(obs_tmo[52]), 0);

    // Spurious done bits on other phases and during START; enable dropped mid-sequence.
    dmode = 3; en_mode = 2;
    do_reset();
    plan(32, -1);
    for (int k = TP + 1; k < TP + 7; k++) drv_done[k][3] = 1'b1;
    drv_done[TP][0] = 1'b1;
    run(32);
    chk("spurious_no_advance", -1, first_start(1, 32), TP + 1 + 6 + 2);
    chk("disabled_tick_ignored", -1, 32'(obs_busy[3 * TP]), 0);
    chk("disabled_no_overrun", -1, 32'(obs_ovr[31]), 1);

    // Reset in WAIT on phase 2, then the first tick after release starts phase 0.
    dmode = 4; en_mode = 0;
    do_reset();
    plan(20, -1);
    run(20);
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    dmode = 0;
    do_reset();
    plan(15, -1);
    run(15);
    chk("restart_phase0", -1, first_start(0, 15), TP + 1);

    // Randomized delays, enables, clears and spurious done bits.
    dmode = 5; en_mode = 1; clr_pct = 3; spur_pct = 20;
    do_reset();
    plan(1500, -1);
    run(1500);

    // Long run of fully timed-out sequences to saturate the overrun counter.
    dmode = 2; en_mode = 0; clr_pct = 0; spur_pct = 0;
    do_reset();
    plan(4200, -1);
    run(4200);
    chk("overrun_saturate", -1, 32'(obs_ovr[4199]), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
